// File: rtl/timing_detector.sv
// rtl/timing_detector.sv - video timing measurement, lock detection and active-area coordinate recovery
//
// Measures the incoming raster (line period, lines per frame, active width,
// active lines), publishes the measurements once per frame on the vSync rising
// edge, and declares lock after consecutive identical, non-saturated frames.
// It also recovers the pixel coordinates inside the active area.
//
// Ports:
//   pixel_clk            sole clock, rising edge
//   reset                asynchronous, active-high
//   hSync, vSync, vde    active-high sync / data-enable, synchronous to pixel_clk
//   total_x, total_y     pixels per line, lines per frame
//   active_x, active_y   vde-high pixels per line, vde-active lines per frame
//   pos_x, pos_y         active-area coordinates, qualified by pos_valid
//   locked               high while the timing is stable
//   err_count            lock-loss event counter
//
// Optional feature: define TIMING_DET_ERRCNT_EN to count LOCKED->TRACK
// transitions on err_count; otherwise err_count is tied to 0.
module timing_detector #(
   parameter int W           = 12,
   parameter int LOCK_FRAMES = 2
) (
   input  logic         pixel_clk,
   input  logic         reset,
   input  logic         hSync,
   input  logic         vSync,
   input  logic         vde,
   output logic [W-1:0] total_x,
   output logic [W-1:0] total_y,
   output logic [W-1:0] active_x,
   output logic [W-1:0] active_y,
   output logic [W-1:0] pos_x,
   output logic [W-1:0] pos_y,
   output logic         pos_valid,
   output logic         locked,
   output logic [15:0]  err_count
);

   localparam logic [W-1:0] MAX = {W{1'b1}};

   typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      return (v == MAX) ? v : v + 1'b1;
   endfunction

   logic         hs1, hs2, vs1, vs2, de1, de2;
   logic         h_rise, v_rise, de_rise, de_fall;
   logic [W-1:0] h_cnt, h_hold;     // line period
   logic [W-1:0] a_cnt, a_hold;     // active width
   logic [W-1:0] l_cnt;             // hSync edges this frame
   logic [W-1:0] al_cnt;            // active lines this frame
   logic         frame_inv, any_sat, frame_bad, meas_eq, frame_ok;
   state_t       state, state_nx;
   logic [3:0]   match_cnt, match_nx;

   // Edges are taken between stage 1 and stage 2 so every derived output
   // lines up with the stage-2 copy of the inputs.
   assign h_rise  = hs1 & ~hs2;
   assign v_rise  = vs1 & ~vs2;
   assign de_rise = de1 & ~de2;
   assign de_fall = ~de1 & de2;

   assign any_sat   = (h_cnt == MAX) | (a_cnt == MAX) | (l_cnt == MAX) | (al_cnt == MAX);
   assign frame_bad = frame_inv | any_sat;
   assign meas_eq   = (h_hold == total_x) && (l_cnt == total_y) &&
                      (a_hold == active_x) && (al_cnt == active_y);
   assign frame_ok  = meas_eq & ~frame_bad;

   assign pos_valid = de2;
   assign locked    = (state == LOCKED);

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         hs1 <= 1'b0; hs2 <= 1'b0;
         vs1 <= 1'b0; vs2 <= 1'b0;
         de1 <= 1'b0; de2 <= 1'b0;
         h_cnt     <= '0; h_hold <= '0;
         a_cnt     <= '0; a_hold <= '0;
         l_cnt     <= '0; al_cnt <= '0;
         total_x   <= '0; total_y  <= '0;
         active_x  <= '0; active_y <= '0;
         pos_x     <= '0; pos_y    <= '0;
         frame_inv <= 1'b0;
      end else begin
         hs1 <= hSync; hs2 <= hs1;
         vs1 <= vSync; vs2 <= vs1;
         de1 <= vde;   de2 <= de1;

         // The edge cycle is the first cycle of the new line.
         if (h_rise) begin
            h_hold <= h_cnt;
            h_cnt  <= W'(1);
         end else begin
            h_cnt  <= sat_inc(h_cnt);
         end

         if (de_fall) begin
            a_hold <= a_cnt;
            a_cnt  <= '0;
         end else if (de1) begin
            a_cnt  <= sat_inc(a_cnt);
         end

         // Coincident line events belong to the frame that is just starting.
         if (v_rise) begin
            total_x   <= h_hold;
            total_y   <= l_cnt;
            active_x  <= a_hold;
            active_y  <= al_cnt;
            l_cnt     <= h_rise  ? W'(1) : '0;
            al_cnt    <= de_fall ? W'(1) : '0;
            frame_inv <= 1'b0;
         end else begin
            if (h_rise)  l_cnt  <= sat_inc(l_cnt);
            if (de_fall) al_cnt <= sat_inc(al_cnt);
            if (any_sat) frame_inv <= 1'b1;
         end

         if (de_rise)  pos_x <= '0;
         else if (de1) pos_x <= sat_inc(pos_x);

         if (v_rise)       pos_y <= '0;
         else if (de_fall) pos_y <= sat_inc(pos_y);
      end
   end

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         state     <= SEARCH;
         match_cnt <= '0;
      end else begin
         state     <= state_nx;
         match_cnt <= match_nx;
      end
   end

   // A match means the new frame equals the previous one, so match_cnt+1
   // matches span match_cnt+2 identical frames.
   always_comb begin
      state_nx = state;
      match_nx = match_cnt;
      if (v_rise) begin
         case (state)
            SEARCH: begin
               state_nx = TRACK;
               match_nx = '0;
            end
            TRACK: begin
               if (frame_ok) begin
                  if (int'(match_cnt) + 2 >= LOCK_FRAMES) begin
                     state_nx = LOCKED;
                     match_nx = '0;
                  end else begin
                     match_nx = match_cnt + 4'd1;
                  end
               end else begin
                  match_nx = '0;
               end
            end
            LOCKED: begin
               if (!frame_ok) begin
                  state_nx = TRACK;
                  match_nx = '0;
               end
            end
            default: begin
               state_nx = SEARCH;
               match_nx = '0;
            end
         endcase
      end
   end

`ifdef TIMING_DET_ERRCNT_EN
   logic lose;
   assign lose = v_rise & (state == LOCKED) & ~frame_ok;

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset)
         err_count <= '0;
      else if (lose && err_count != 16'hFFFF)
         err_count <= err_count + 16'd1;
   end
`else
   assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_timing_detector.sv
// tb/tb_timing_detector.sv - directed self-checking bench for timing_detector
module tb_timing_detector;

   localparam int W   = 12;
   // Reduced raster with the same structure as 800x525 / 640x480.
   localparam int HT  = 50;
   localparam int HA  = 32;
   localparam int HS0 = 36;
   localparam int HS1 = 39;
   localparam int VT  = 30;
   localparam int VA  = 20;
   localparam int VS0 = 24;
   localparam int VS1 = 25;

`ifdef TIMING_DET_ERRCNT_EN
   localparam int ERR_ON = 1;
`else
   localparam int ERR_ON = 0;
`endif

   logic         pixel_clk = 1'b0;
   logic         reset     = 1'b1;
   logic         hSync     = 1'b0;
   logic         vSync     = 1'b0;
   logic         vde       = 1'b0;
   logic [W-1:0] total_x, total_y, active_x, active_y, pos_x, pos_y;
   logic         pos_valid, locked;
   logic [15:0]  err_count;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   timing_detector #(.W(W), .LOCK_FRAMES(2)) dut (
      .pixel_clk (pixel_clk),
      .reset     (reset),
      .hSync     (hSync),
      .vSync     (vSync),
      .vde       (vde),
      .total_x   (total_x),
      .total_y   (total_y),
      .active_x  (active_x),
      .active_y  (active_y),
      .pos_x     (pos_x),
      .pos_y     (pos_y),
      .pos_valid (pos_valid),
      .locked    (locked),
      .err_count (err_count)
   );

   always #5 pixel_clk = ~pixel_clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge pixel_clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " total_x"},   32'(total_x),   0);
      check({tag, " total_y"},   32'(total_y),   0);
      check({tag, " active_x"},  32'(active_x),  0);
      check({tag, " active_y"},  32'(active_y),  0);
      check({tag, " pos_x"},     32'(pos_x),     0);
      check({tag, " pos_y"},     32'(pos_y),     0);
      check({tag, " pos_valid"}, 32'(pos_valid), 0);
      check({tag, " locked"},    32'(locked),    0);
      check({tag, " err_count"}, 32'(err_count), 0);
   endtask

   // Drives lines y0..y1-1; outputs after each tick reflect the pixel driven
   // one iteration earlier (two pipeline stages).
   task automatic run_lines(input int y0, input int y1, input int stretch_y, input bit chk_pos);
      int px = -1;
      int py = -1;
      for (int y = y0; y < y1; y++) begin
         for (int x = 0; x < ((y == stretch_y) ? HT + 1 : HT); x++) begin
            hSync = (x >= HS0 && x <= HS1);
            vSync = (y >= VS0 && y <= VS1);
            vde   = (x < HA && y < VA);
            tick();
            if (chk_pos) begin
               if (px == 0 && py == 0) begin
                  check("first pos_valid", 32'(pos_valid), 1);
                  check("first pos_x",     32'(pos_x),     0);
                  check("first pos_y",     32'(pos_y),     0);
               end
               if (px == HA - 1 && py == VA - 1) begin
                  check("last pos_valid", 32'(pos_valid), 1);
                  check("last pos_x",     32'(pos_x),     HA - 1);
                  check("last pos_y",     32'(pos_y),     VA - 1);
               end
               if (px == HA && py == 0) begin
                  check("blank pos_valid", 32'(pos_valid), 0);
               end
            end
            px = x;
            py = y;
         end
      end
   endtask

   // Two hSync edges 5001 cycles apart, then a vSync pulse.
   task automatic bad_frame();
      vde   = 1'b0;
      vSync = 1'b0;
      hSync = 1'b1; tick();
      hSync = 1'b0; repeat (5000) tick();
      hSync = 1'b1; tick();
      hSync = 1'b0; repeat (10) tick();
      vSync = 1'b1; repeat (3) tick();
      vSync = 1'b0; repeat (10) tick();
   endtask

   initial begin
      // Reset state
      reset = 1'b1;
      repeat (3) tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // Acquisition: partial first frame, then two full frames
      run_lines(0, VT, -1, 1'b0);
      check("f0 total_x",  32'(total_x),  HT);
      check("f0 total_y",  32'(total_y),  VS0);
      check("f0 active_x", 32'(active_x), HA);
      check("f0 active_y", 32'(active_y), VA);
      check("f0 locked",   32'(locked),   0);
      run_lines(0, VT, -1, 1'b0);
      check("f1 total_y",  32'(total_y),  VT);
      check("f1 locked",   32'(locked),   0);
      run_lines(0, VT, -1, 1'b1);
      check("f2 total_x",  32'(total_x),  HT);
      check("f2 total_y",  32'(total_y),  VT);
      check("f2 active_x", 32'(active_x), HA);
      check("f2 active_y", 32'(active_y), VA);
      check("f2 locked",   32'(locked),   1);

      // One line stretched by a cycle, last line period before vSync
      run_lines(0, VT, VS0 - 2, 1'b0);
      check("stretch total_x",   32'(total_x),   HT + 1);
      check("stretch total_y",   32'(total_y),   VT);
      check("stretch locked",    32'(locked),    0);
      check("stretch err_count", 32'(err_count), ERR_ON);
      run_lines(0, VT, -1, 1'b0);
      check("clean1 total_x", 32'(total_x), HT);
      check("clean1 locked",  32'(locked),  0);
      run_lines(0, VT, -1, 1'b0);
      check("clean2 locked",    32'(locked),    1);
      check("clean2 err_count", 32'(err_count), ERR_ON);

      // Reset in the middle of a frame
      run_lines(0, 10, -1, 1'b0);
      #1;
      reset = 1'b1;
      #1;
      check_all_zero("midreset");
      tick();
      reset = 1'b0;
      run_lines(10, VT, -1, 1'b0);
      check("post-reset partial total_y", 32'(total_y), VS0 - 10);
      check("post-reset partial locked",  32'(locked),  0);
      run_lines(0, VT, -1, 1'b0);
      check("post-reset f1 locked", 32'(locked), 0);
      run_lines(0, VT, -1, 1'b0);
      check("post-reset f2 locked",  32'(locked),  1);
      check("post-reset f2 total_y", 32'(total_y), VT);

      // Saturated line period: identical frames but never valid
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bad_frame();
      check("sat1 total_x", 32'(total_x), 4095);
      check("sat1 total_y", 32'(total_y), 2);
      check("sat1 locked",  32'(locked),  0);
      bad_frame();
      check("sat2 total_x", 32'(total_x), 4095);
      check("sat2 locked",  32'(locked),  0);
      bad_frame();
      check("sat3 total_y", 32'(total_y), 2);
      check("sat3 locked",  32'(locked),  0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/timing_detector.md
TIMING_DETECTOR -- requirements
Module: timing_detector

Interface
REQ-001 SHALL have parameter W, default 12: width of all measurement and coordinate counters.
REQ-002 SHALL have parameter LOCK_FRAMES, default 2: consecutive identical frames required for lock (range 1-15).
REQ-003 SHALL have port pixel_clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports hSync, vSync, vde, inputs, 1 each: active-high sync and data-enable, synchronous to pixel_clk.
REQ-006 SHALL have ports total_x and total_y, outputs, W each: measured pixels per line and lines per frame.
REQ-007 SHALL have ports active_x and active_y, outputs, W each: measured vde-high pixels per line and vde-active lines per frame.
REQ-008 SHALL have ports pos_x and pos_y, outputs, W each, plus pos_valid, output, 1: recovered active-area coordinates.
REQ-009 SHALL have port locked, output, 1: stable-timing indicator.
REQ-010 SHALL have port err_count, output, 16: lock-loss counter (see Configuration).

Function
REQ-011 SHALL register hSync, vSync and vde through two stages; rising/falling edges are detected between stage 1 and stage 2, giving 2-cycle latency from port to every derived output.
REQ-012 SHALL count cycles between consecutive hSync rising edges; on each edge, latch the count (edge cycle inclusive) into the line-period holding register, restart at 1.
REQ-013 SHALL count vde-high cycles per line; latch into the active-width holding register on each vde falling edge.
REQ-014 SHALL count hSync rising edges since the last vSync rising edge; on vSync rising edge, latch it as line total and restart at 0; a coincident hSync edge counts into the new frame (count becomes 1).
REQ-015 SHALL count vde falling edges per frame; latch as active line count on vSync rising edge and restart at 0.
REQ-016 SHALL update total_x, total_y, active_x, active_y together, only on vSync rising edge, from the holding registers.
REQ-017 SHALL saturate every counter at 2^W-1; a saturated value flags the frame as invalid.
REQ-018 SHALL drive pos_valid = stage-2 vde; pos_x = 0 on the first pos_valid cycle of a line, +1 per following valid cycle; pos_y = 0 for first active line after vSync rising edge, +1 per vde falling edge.
REQ-019 SHALL implement FSM SEARCH -> TRACK -> LOCKED: SEARCH waits for first vSync rising edge, then TRACK with match counter 0.
REQ-020 In TRACK, each vSync rising edge SHALL compare new measurements with current outputs: equal and valid -> match counter +1, reaching LOCK_FRAMES -> LOCKED; otherwise match counter 0.
REQ-021 In LOCKED, any mismatching or invalid frame SHALL return to TRACK with match counter 0 and deassert locked in the same cycle the outputs update.
REQ-022 locked SHALL be high only in LOCKED.
REQ-023 SHALL treat missing hSync edges during a frame only via resulting total mismatch; no timeout.

Reset
REQ-024 Reset asserted SHALL immediately clear all counters, holding registers, outputs and err_count to 0, pos_valid and locked to 0, FSM to SEARCH.
REQ-025 Reset mid-frame SHALL discard partial measurements; first frame after release is not compared.

Configuration
REQ-026 Macro TIMING_DET_ERRCNT_EN defined: err_count SHALL increment on each LOCKED->TRACK transition, saturating at 0xFFFF.
REQ-027 Macro undefined: err_count port SHALL remain present and tied to 0; no counter logic.

Verification
REQ-028 640x480 stream (800x525, hSync 656-751, vSync lines 490-491, vde X<640,Y<480), 3 frames -> total_x=800, total_y=525, active_x=640, active_y=480; locked high after 3rd vSync edge (LOCK_FRAMES=2).
REQ-029 Locked, one line stretched to 801 cycles -> next vSync edge: total_x=801, locked low, err_count=1 (macro on) / 0 (off); relock after 2 clean frames.
REQ-030 Active pixel X=0,Y=0 at port -> 2 cycles later pos_valid=1, pos_x=0, pos_y=0; last active pixel -> pos_x=639, pos_y=479.
REQ-031 Reset pulsed mid-frame 200 -> all outputs 0 immediately, FSM SEARCH; lock regained after 3 further frames.
REQ-032 hSync held low for 5000 cycles -> line counter saturates at 4095, frame invalid, locked stays low.
